adpll_pi_core: RTL and testbench

//  Fully synchronous all-digital PLL for the SWIPT link. A phase/frequency detector, a PI loop filter and an NCO run in the clk domain.

---
 rtl/adpll_pkg.sv | 23 ++
 rtl/adpll_pfd.sv | 101 ++++++++++
 rtl/adpll_pi_core.sv | 83 ++++++++
 tb/tb_adpll_pi_core.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/adpll_pkg.sv
// Shared types and saturating arithmetic helpers for the ADPLL core.
// All loop-filter math is done in a wide signed type so that clamping never sees overflow.
package adpll_pkg;
  typedef enum logic [1:0] {IDLE, REF_LEAD, NCO_LEAD} pfd_state_e;

  localparam int CALC_W = 64;
  typedef logic signed [CALC_W-1:0] calc_t;

  // Symmetric saturating add: result limited to [-lim, lim]
  function automatic calc_t sat_add(input calc_t a, input calc_t b, input calc_t lim);
    calc_t s;
    s = a + b;
    if (s > lim) return lim;
    if (s < -lim) return -lim;
    return s;
  endfunction

  function automatic calc_t clamp_fcw(input calc_t v, input calc_t lo, input calc_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction
endpackage

// File: rtl/adpll_pfd.sv
// Phase/frequency detector: ref synchroniser, edge detection and a signed,
// saturating cycle counter that reports the lead/lag between ref and NCO edges.
module adpll_pfd import adpll_pkg::*; #(
  parameter int ERR_W = 16
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    en,
  input  logic                    ref_in,
  input  logic                    nco,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    err_valid
);
  localparam calc_t CNT_MAX = (calc_t'(1) <<< (ERR_W-1)) - calc_t'(1);
  localparam logic signed [ERR_W-1:0] ERR_MAX = ERR_W'(CNT_MAX);

  logic [2:0] ref_sync;
  logic       nco_d;
  logic       ref_rise, nco_rise;
  pfd_state_e state, state_n;
  logic [ERR_W-1:0] cnt, cnt_n, cnt_inc;
  logic signed [ERR_W-1:0] err_n;
  logic vld_n;

  assign ref_rise = ref_sync[1] & ~ref_sync[2];
  assign nco_rise = nco & ~nco_d;
  assign cnt_inc  = ERR_W'(sat_add(calc_t'(cnt), calc_t'(1), CNT_MAX));

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    err_n   = phase_err;
    vld_n   = 1'b0;
    unique case (state)
      IDLE: begin
        if (ref_rise && nco_rise) begin
          err_n = '0;
          vld_n = 1'b1;
        end else if (ref_rise) begin
          state_n = REF_LEAD;
          cnt_n   = ERR_W'(1);
        end else if (nco_rise) begin
          state_n = NCO_LEAD;
          cnt_n   = ERR_W'(1);
        end
      end
      REF_LEAD: begin
        cnt_n = cnt_inc;
        if (nco_rise) begin
          err_n   = $signed(cnt);
          vld_n   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (ref_rise) begin
          // a second ref edge before any NCO edge is a cycle slip
          err_n = ERR_MAX;
          vld_n = 1'b1;
          cnt_n = ERR_W'(1);
        end
      end
      NCO_LEAD: begin
        cnt_n = cnt_inc;
        if (ref_rise) begin
          err_n   = -$signed(cnt);
          vld_n   = 1'b1;
          state_n = IDLE;
          cnt_n   = '0;
        end else if (nco_rise) begin
          err_n = -ERR_MAX;
          vld_n = 1'b1;
          cnt_n = ERR_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      ref_sync  <= '0;
      nco_d     <= 1'b0;
      state     <= IDLE;
      cnt       <= '0;
      phase_err <= '0;
      err_valid <= 1'b0;
    end else begin
      ref_sync <= {ref_sync[1:0], ref_in};
      nco_d    <= nco;
      if (!en) begin
        state     <= IDLE;
        cnt       <= '0;
        err_valid <= 1'b0;
      end else begin
        state     <= state_n;
        cnt       <= cnt_n;
        phase_err <= err_n;
        err_valid <= vld_n;
      end
    end
  end
endmodule

// File: rtl/adpll_pi_core.sv
// ADPLL top: PI loop filter with anti-windup, NCO and lock detector around adpll_pfd.
// fcw_out, the integrator and lock state only move on err_valid; NCO free-runs.
module adpll_pi_core import adpll_pkg::*; #(
  parameter int               ACC_W    = 32,
  parameter int               ERR_W    = 16,
  parameter logic [ACC_W-1:0] F0_WORD  = 32'h1A36E3,
  parameter logic [ACC_W-1:0] FCW_MIN  = 32'h16F007,
  parameter logic [ACC_W-1:0] FCW_MAX  = 32'h1D7DBF,
  parameter int               KP_SHIFT = 6,
  parameter int               KI_SHIFT = 2,
  parameter int               LOCK_TOL = 2,
  parameter int               LOCK_CNT = 8
) (
  input  logic                    clk,
  input  logic                    nrst,
  input  logic                    en,
  input  logic                    ref_in,
  output logic                    nco_out,
  output logic [ACC_W-1:0]        fcw_out,
  output logic signed [ERR_W-1:0] phase_err,
  output logic                    err_valid,
  output logic                    locked
);
  localparam int W   = ACC_W + 2;
  localparam int LCW = $clog2(LOCK_CNT + 1);
  // integrator bounds keep F0_WORD+integ inside the FCW clamp window
  localparam calc_t INT_LO = calc_t'(FCW_MIN) - calc_t'(F0_WORD);
  localparam calc_t INT_HI = calc_t'(FCW_MAX) - calc_t'(F0_WORD);

  logic [ACC_W-1:0]    acc;
  logic signed [W-1:0] integ;
  logic [LCW-1:0]      lock_cnt;
  calc_t               err, integ_n, fcw_n;
  logic                in_tol;

  adpll_pfd #(.ERR_W(ERR_W)) u_pfd (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .ref_in    (ref_in),
    .nco       (nco_out),
    .phase_err (phase_err),
    .err_valid (err_valid)
  );

  always_comb begin
    err     = calc_t'(phase_err);
    integ_n = clamp_fcw(calc_t'(integ) + (err <<< KI_SHIFT), INT_LO, INT_HI);
    fcw_n   = clamp_fcw(calc_t'(F0_WORD) + integ_n + (err <<< KP_SHIFT),
                        calc_t'(FCW_MIN), calc_t'(FCW_MAX));
    in_tol  = (err <= calc_t'(LOCK_TOL)) && (err >= -calc_t'(LOCK_TOL));
  end

  always_ff @(posedge clk) begin
    if (nrst) begin
      acc      <= '0;
      nco_out  <= 1'b0;
      fcw_out  <= F0_WORD;
      integ    <= '0;
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else begin
      acc     <= acc + fcw_out;
      nco_out <= acc[ACC_W-1];
      if (!en) begin
        fcw_out  <= F0_WORD;
        integ    <= '0;
        lock_cnt <= '0;
        locked   <= 1'b0;
      end else if (err_valid) begin
        integ   <= W'(integ_n);
        fcw_out <= ACC_W'(fcw_n);
        if (in_tol) begin
          if (lock_cnt != LCW'(LOCK_CNT)) lock_cnt <= lock_cnt + 1'b1;
          if (lock_cnt >= LCW'(LOCK_CNT - 1)) locked <= 1'b1;
        end else begin
          lock_cnt <= '0;
          locked   <= 1'b0;
        end
      end
    end
  end
endmodule

// File: tb/tb_adpll_pi_core.sv
// Directed bench for adpll_pi_core: edge timing is scheduled against a cycle
// counter so expected errors and FCW values are known exactly in advance.
module tb_adpll_pi_core;
  logic               clk = 1'b0;
  logic               nrst, en, ref_in;
  logic               nco_out, err_valid, locked;
  logic [31:0]        fcw_out;
  logic signed [15:0] phase_err;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int ref_per = 0, ref_first = 0;
  int n_ev = 0, n_slip = 0, n_unlock = 0, snap = 0;
  logic        mon_lock = 1'b0;
  logic [31:0] fcw_hi = '0;

  localparam logic [31:0] F0   = 32'h1A36E3;
  localparam logic [31:0] FMAX = 32'h1D7DBF;

  adpll_pi_core dut (
    .clk       (clk),
    .nrst      (nrst),
    .en        (en),
    .ref_in    (ref_in),
    .nco_out   (nco_out),
    .fcw_out   (fcw_out),
    .phase_err (phase_err),
    .err_valid (err_valid),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  // cyc == k at the negedge following the k-th edge after reset release
  always @(posedge clk) if (nrst) cyc <= 0; else cyc <= cyc + 1;

  // ref_in rises at the negedge where cyc == ref_first + n*ref_per
  always @(negedge clk) begin
    if (ref_per == 0 || cyc < ref_first) ref_in = 1'b0;
    else ref_in = (((cyc - ref_first) % ref_per) < (ref_per / 2));
  end

  always @(negedge clk) begin
    if (err_valid) begin
      n_ev++;
      if (phase_err == 16'sd32767) n_slip++;
    end
    if (fcw_out > fcw_hi) fcw_hi = fcw_out;
    if (mon_lock && !locked) n_unlock++;
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_to(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic do_reset(input string tag);
    nrst = 1'b1;
    ref_per = 0;
    repeat (2) @(negedge clk);
    chk({tag, "_fcw"}, fcw_out, F0);
    chk({tag, "_nco"}, nco_out, 0);
    chk({tag, "_locked"}, locked, 0);
    chk({tag, "_valid"}, err_valid, 0);
    chk({tag, "_err"}, phase_err, 0);
    nrst = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b1; en = 1'b0;
    do_reset("rst1");

    // ref leads NCO by 7 cycles; first NCO rise is seen by the PFD at edge 1252
    en = 1'b1; ref_first = 1242; ref_per = 1000000;
    wait_to(1250); chk("lead_nco_lo", nco_out, 0); chk("lead_novalid", err_valid, 0);
    wait_to(1251); chk("lead_nco_hi", nco_out, 1);
    wait_to(1252); chk("lead_valid", err_valid, 1); chk("lead_err", phase_err, 7);
    chk("lead_fcw_hold", fcw_out, F0);
    wait_to(1253); chk("lead_pulse", err_valid, 0); chk("lead_fcw", fcw_out, 32'h1A38BF);

    // ref and NCO rise in the same cycle
    do_reset("rst2");
    en = 1'b1; ref_first = 1249; ref_per = 1000000;
    wait_to(1252); chk("same_valid", err_valid, 1); chk("same_err", phase_err, 0);
    wait_to(1253); chk("same_fcw", fcw_out, F0); chk("same_pulse", err_valid, 0);

    // reset in the middle of a REF_LEAD count
    do_reset("rst3");
    en = 1'b1; ref_first = 1000; ref_per = 1000000;
    wait_to(1100);
    snap = n_ev;
    do_reset("rst_mid");
    wait_to(1300); ref_first = 1400; ref_per = 1000000;
    wait_to(1400); chk("mid_no_valid", n_ev - snap, 0);
    // NCO led from edge 1252; ref arrives at edge 1403
    wait_to(1403); chk("nlead_valid", err_valid, 1); chk("nlead_err", phase_err, -151);
    wait_to(1404); chk("nlead_fcw", fcw_out, 1707719);

    // 90 kHz reference: repeated slips drive FCW and integrator into their clamps
    do_reset("rst4");
    en = 1'b1; ref_first = 1; ref_per = 1111;
    snap = n_slip;
    wait_to(12000);
    chk("slip_seen", (n_slip - snap) >= 2, 1);
    chk("slip_fcw", fcw_out, FMAX);
    chk("slip_integ", dut.integ, 214748);
    chk("slip_fcw_hi", fcw_hi <= FMAX, 1);

    // 40 kHz reference aligned with the NCO: lock after 8 zero errors
    do_reset("rst5");
    en = 1'b1; ref_first = 1249; ref_per = 2500;
    wait_to(1252); chk("lk_err0", phase_err, 0); chk("lk_valid0", err_valid, 1);
    wait_to(18752); chk("lk_not_yet", locked, 0);
    wait_to(18753); chk("lk_locked", locked, 1);
    mon_lock = 1'b1;
    wait_to(30000);
    mon_lock = 1'b0;
    chk("lk_held", n_unlock, 0);
    chk("lk_fcw", fcw_out, F0);
    en = 1'b0;
    wait_to(30001); chk("dis_locked", locked, 0); chk("dis_fcw", fcw_out, F0);
    snap = n_ev;
    wait_to(33000); chk("dis_no_valid", n_ev - snap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
